// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, divide opcodes (shared with the
// decoder) and the divider state encoding.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] DIV_OP_DIV  = 3'b100;
  localparam logic [2:0] DIV_OP_DIVU = 3'b101;
  localparam logic [2:0] DIV_OP_REM  = 3'b110;
  localparam logic [2:0] DIV_OP_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: radix-2 restoring division on operand
// magnitudes, one quotient bit per clock, sign fix-up in the final cycle.
//
// state    | meaning
// DIV_IDLE | waiting for a legal div_start; special cases resolved here
// DIV_CALC | one restoring iteration per cycle, XLEN iterations
// DIV_FIN  | apply sign correction, pulse done, return to idle
module div_unit #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);
  import core_pkg::*;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  dvsr_r;
  logic             is_rem_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [4:0]       rd_r;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            is_ovf;
  logic [XLEN:0]   r_shift;
  logic            trial_ok;
  logic [XLEN-1:0] rem_next;

  always_comb begin
    is_signed = ~div_op[0];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_abs     = cond_neg(dividend, a_neg);
    b_abs     = cond_neg(divisor, b_neg);
    is_ovf    = is_signed && (dividend == MOST_NEG) && (divisor == '1);
  end

  // R grows to XLEN+1 bits after the shift when the divisor is large, so the
  // trial subtract is done at XLEN+1 bits and only the kept value is truncated.
  always_comb begin
    r_shift  = {rem_r, quo_r[XLEN-1]};
    trial_ok = r_shift >= {1'b0, dvsr_r};
    rem_next = trial_ok ? XLEN'(r_shift - {1'b0, dvsr_r}) : r_shift[XLEN-1:0];
  end

  assign busy = (state != DIV_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DIV_IDLE;
      count    <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      rd_r     <= '0;
      done     <= 1'b0;
      wb_en    <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (div_start && div_op[2] && !flush) begin
            is_rem_r <= div_op[1];
            rd_r     <= rd_in;
            count    <= '0;
            dvsr_r   <= b_abs;
            if (divisor == '0) begin
              quo_r   <= '1;
              rem_r   <= dividend;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
              state   <= DIV_FIN;
            end else if (is_ovf) begin
              quo_r   <= MOST_NEG;
              rem_r   <= '0;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
              state   <= DIV_FIN;
            end else begin
              quo_r   <= a_abs;
              rem_r   <= '0;
              neg_q_r <= a_neg ^ b_neg;
              neg_r_r <= a_neg;
              state   <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          if (flush) begin
            state <= DIV_IDLE;
          end else begin
            quo_r <= {quo_r[XLEN-2:0], trial_ok};
            rem_r <= rem_next;
            count <= count + 1'b1;
            if (count == CNT_W'(XLEN-1)) state <= DIV_FIN;
          end
        end
        DIV_FIN: begin
          state <= DIV_IDLE;
          if (!flush) begin
            done   <= 1'b1;
            wb_en  <= (rd_r != 5'd0);
            rd_out <= rd_r;
            result <= is_rem_r ? cond_neg(rem_r, neg_r_r) : cond_neg(quo_r, neg_q_r);
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
